// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared screen geometry, fixed-point scale and character state encoding
package game_pkg;

    localparam int FIXED_POINT_MULTIPLIER = 64;
    localparam int FP_SHIFT               = 6;
    localparam int X_FRAME_MAX            = 639;
    localparam int Y_FRAME_MAX            = 479;

    typedef enum logic [1:0] {
        STAND      = 2'd0,
        WALK_LEFT  = 2'd1,
        WALK_RIGHT = 2'd2,
        FROZEN     = 2'd3
    } char_state_t;

endpackage

// File: rtl/crash_latch.sv
// rtl/crash_latch.sv - sticky left/right crash flags, cleared at each frame boundary
module crash_latch (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic start_of_frame,
    input  logic set_left,
    input  logic set_right,
    output logic crash_left,
    output logic crash_right
);

    logic [1:0] flags_d;
    logic [1:0] flags_q;

    // A set coincident with the boundary lands in the freshly cleared flags
    always_comb begin
        flags_d = flags_q;
        if (clear) begin
            flags_d = 2'b00;
        end else if (start_of_frame) begin
            flags_d = {set_left, set_right};
        end else begin
            flags_d = flags_q | {set_left, set_right};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 2'b00;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign crash_left  = flags_q[1];
    assign crash_right = flags_q[0];

endmodule

// File: rtl/char_move.sv
// rtl/char_move.sv - per-frame horizontal motion of the player character with border blocking
module char_move
    import game_pkg::*;
#(
    parameter int INIT_X     = 288,
    parameter int INIT_Y     = 416,
    parameter int X_SPEED    = 128,
    parameter int CHAR_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        leftPress,
    input  logic        rightPress,
    input  logic        charCrashLeft,
    input  logic        charCrashRight,
    input  logic        freeze,
    input  logic        restart,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        facingLeft,
    output logic        moving
);

    localparam int X_MAX = X_FRAME_MAX + 1 - CHAR_WIDTH;
    localparam logic signed [17:0] INIT_FP = 18'(INIT_X * FIXED_POINT_MULTIPLIER);
    localparam logic signed [18:0] STEP    = 19'(X_SPEED);
    localparam logic signed [18:0] XMAX_FP = 19'(X_MAX * FIXED_POINT_MULTIPLIER);

    char_state_t       state_d, state_q;
    logic signed [17:0] pos_x_d, pos_x_q;
    logic               facing_d, facing_q;
    logic               crash_l, crash_r;
    logic signed [18:0] pos_ext;
    logic signed [18:0] pos_sum;
    logic signed [17:0] pos_shift;

    crash_latch u_crash_latch (
        .clk            (clk),
        .reset          (reset),
        .clear          (restart),
        .start_of_frame (startOfFrame),
        .set_left       (charCrashLeft),
        .set_right      (charCrashRight),
        .crash_left     (crash_l),
        .crash_right    (crash_r)
    );

    always_comb begin
        state_d  = state_q;
        pos_x_d  = pos_x_q;
        facing_d = facing_q;
        pos_ext  = {pos_x_q[17], pos_x_q};
        pos_sum  = pos_ext;

        if (restart) begin
            state_d  = STAND;
            pos_x_d  = INIT_FP;
            facing_d = 1'b0;
        end else if (startOfFrame) begin
            if (freeze || state_q == FROZEN) begin
                state_d = FROZEN;
            end else if (leftPress && !rightPress) begin
                state_d = WALK_LEFT;
            end else if (rightPress && !leftPress) begin
                state_d = WALK_RIGHT;
            end else begin
                state_d = STAND;
            end

            // The step uses the state just decided and the flags from the frame just drawn
            if (state_d == WALK_LEFT) begin
                facing_d = 1'b1;
                if (!crash_l) begin
                    pos_sum = pos_ext - STEP;
                end
            end else if (state_d == WALK_RIGHT) begin
                facing_d = 1'b0;
                if (!crash_r) begin
                    pos_sum = pos_ext + STEP;
                end
            end

            if (pos_sum < 19'sd0) begin
                pos_x_d = 18'sd0;
            end else if (pos_sum > XMAX_FP) begin
                pos_x_d = XMAX_FP[17:0];
            end else begin
                pos_x_d = pos_sum[17:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= STAND;
            pos_x_q  <= INIT_FP;
            facing_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_x_q  <= pos_x_d;
            facing_q <= facing_d;
        end
    end

    assign pos_shift  = pos_x_q >>> FP_SHIFT;
    assign topLeftX   = pos_shift[10:0];
    assign topLeftY   = 11'(INIT_Y);
    assign facingLeft = facing_q;
    assign moving     = (state_q == WALK_LEFT) || (state_q == WALK_RIGHT);

endmodule

// File: tb/tb_char_move.sv
// tb/tb_char_move.sv - scoreboard bench for char_move with directed frame sequences
module tb_char_move;

    logic        clk;
    logic        reset;
    logic        startOfFrame;
    logic        leftPress;
    logic        rightPress;
    logic        charCrashLeft;
    logic        charCrashRight;
    logic        freeze;
    logic        restart;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        facingLeft;
    logic        moving;

    typedef struct {
        logic [10:0] x;
        logic        mv;
        logic        fc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    logic tb_chk;
    logic chk_seen;
    logic inv_en;
    int   checks;
    int   failures;

    char_move dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .leftPress      (leftPress),
        .rightPress     (rightPress),
        .charCrashLeft  (charCrashLeft),
        .charCrashRight (charCrashRight),
        .freeze         (freeze),
        .restart        (restart),
        .topLeftX       (topLeftX),
        .topLeftY       (topLeftY),
        .facingLeft     (facingLeft),
        .moving         (moving)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) chk_seen <= tb_chk;

    always @(negedge clk) begin
        exp_t e;
        if (inv_en) begin
            checks++;
            if (topLeftX > 11'd608) begin
                failures++;
                $display("FAIL x_range: topLeftX=%0d required<=608", topLeftX);
            end
            checks++;
            if (topLeftY !== 11'd416) begin
                failures++;
                $display("FAIL y_const: topLeftY=%0d required=416", topLeftY);
            end
        end
        if (chk_seen) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty: output presented with no expectation queued");
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (topLeftX !== e.x) begin
                    failures++;
                    $display("FAIL %s x: got=%0d exp=%0d", e.name, topLeftX, e.x);
                end
                checks++;
                if (moving !== e.mv) begin
                    failures++;
                    $display("FAIL %s moving: got=%0b exp=%0b", e.name, moving, e.mv);
                end
                checks++;
                if (facingLeft !== e.fc) begin
                    failures++;
                    $display("FAIL %s facing: got=%0b exp=%0b", e.name, facingLeft, e.fc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [10:0] x, input logic mv, input logic fc, input string nm);
        exp_t e;
        e.x = x; e.mv = mv; e.fc = fc; e.name = nm;
        exp_q.push_back(e);
        tb_chk = 1'b1;
    endtask

    task automatic frame(input logic l, input logic r, input logic fz, input logic cl, input logic cr,
                         input logic chk, input logic [10:0] ex, input logic mv, input logic fc,
                         input string nm);
        leftPress      = l;
        rightPress     = r;
        freeze         = fz;
        charCrashLeft  = cl;
        charCrashRight = cr;
        startOfFrame   = 1'b1;
        if (chk) expect_out(ex, mv, fc, nm);
        tick();
        startOfFrame   = 1'b0;
        charCrashLeft  = 1'b0;
        charCrashRight = 1'b0;
        tb_chk         = 1'b0;
        repeat (3) tick();
    endtask

    task automatic mid_crash(input logic cl, input logic cr);
        charCrashLeft  = cl;
        charCrashRight = cr;
        tick();
        charCrashLeft  = 1'b0;
        charCrashRight = 1'b0;
        tick();
    endtask

    task automatic restart_pulse(input logic with_sof, input string nm);
        restart      = 1'b1;
        startOfFrame = with_sof;
        expect_out(11'd288, 1'b0, 1'b0, nm);
        tick();
        restart      = 1'b0;
        startOfFrame = 1'b0;
        tb_chk       = 1'b0;
        repeat (2) tick();
    endtask

    task automatic reset_pulse(input int cycles, input string nm);
        reset = 1'b1;
        if (cycles > 1) repeat (cycles - 1) tick();
        expect_out(11'd288, 1'b0, 1'b0, nm);
        tick();
        reset  = 1'b0;
        tb_chk = 1'b0;
        inv_en = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        checks = 0; failures = 0;
        tb_chk = 1'b0; inv_en = 1'b0;
        reset = 1'b1; startOfFrame = 1'b0; leftPress = 1'b0; rightPress = 1'b0;
        charCrashLeft = 1'b0; charCrashRight = 1'b0; freeze = 1'b0; restart = 1'b0;

        reset_pulse(2, "reset");

        for (int i = 1; i <= 10; i++) frame(0, 1, 0, 0, 0, i == 10, 11'd308, 1, 0, "walk_right10");
        for (int i = 1; i <= 104; i++) frame(1, 0, 0, 0, 0, i == 104, 11'd100, 1, 1, "walk_to_100");

        mid_crash(1, 0);
        frame(1, 0, 0, 0, 0, 1, 11'd100, 1, 1, "crash_mid_block");
        frame(1, 0, 0, 0, 0, 1, 11'd98, 1, 1, "crash_mid_clear");
        frame(0, 1, 0, 0, 0, 1, 11'd100, 1, 0, "back_to_100");

        frame(1, 0, 0, 1, 0, 1, 11'd98, 1, 1, "crash_sof_moves");
        frame(1, 0, 0, 0, 0, 1, 11'd98, 1, 1, "crash_sof_blocks_next");
        frame(1, 0, 0, 0, 0, 1, 11'd96, 1, 1, "crash_sof_cleared");
        mid_crash(0, 1);
        frame(1, 0, 0, 0, 0, 1, 11'd94, 1, 1, "away_from_crash");

        for (int i = 1; i <= 200; i++)
            frame(1, 0, 0, 0, 0, (i == 46) || (i == 47) || (i == 200),
                  (i == 46) ? 11'd2 : 11'd0, 1, 1, "sat_left");
        for (int i = 1; i <= 310; i++)
            frame(0, 1, 0, 0, 0, (i == 303) || (i == 304) || (i == 310),
                  (i == 303) ? 11'd606 : 11'd608, 1, 0, "sat_right");

        frame(1, 1, 0, 0, 0, 1, 11'd608, 0, 0, "both_keys_stand");
        frame(1, 0, 0, 0, 0, 1, 11'd606, 1, 1, "left_after_stand");
        frame(1, 0, 1, 0, 0, 1, 11'd606, 0, 1, "freeze_enter");
        frame(0, 1, 0, 0, 0, 1, 11'd606, 0, 1, "frozen_holds");
        restart_pulse(0, "restart");
        frame(0, 1, 0, 0, 0, 1, 11'd290, 1, 0, "walk_after_restart");
        rightPress = 1'b1;
        restart_pulse(1, "restart_over_sof");
        frame(1, 0, 0, 0, 0, 1, 11'd286, 1, 1, "left_after_restart");
        mid_crash(1, 0);
        restart_pulse(0, "restart_clears_flag");
        frame(1, 0, 0, 0, 0, 1, 11'd286, 1, 1, "flag_cleared_by_restart");
        frame(1, 0, 0, 0, 0, 0, 11'd0, 0, 0, "walk");
        reset_pulse(1, "reset_mid_walk");
        frame(1, 0, 0, 0, 0, 1, 11'd286, 1, 1, "walk_after_reset");

        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
